// File: rtl/iter_mul_unit.sv
// Iterative shift-and-add multiplier: one multiplier bit per cycle, low p_nbits of the product.
// Optional macro ITER_MUL_EARLY_EXIT_EN ends the CALC phase as soon as the remaining multiplier is zero.
module iter_mul_unit #(
    parameter int p_nbits = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req_val,
    output logic               req_rdy,
    input  logic [p_nbits-1:0] req_msg_a,
    input  logic [p_nbits-1:0] req_msg_b,
    output logic               resp_val,
    input  logic               resp_rdy,
    output logic [p_nbits-1:0] resp_msg
);

    localparam int CW = $clog2(p_nbits);
    localparam logic [CW-1:0] C_LAST = CW'(p_nbits - 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [p_nbits-1:0] r_a;
    logic [p_nbits-1:0] r_b;
    logic [p_nbits-1:0] r_result;
    logic [CW-1:0]      r_cnt;
    logic               w_accept;
    logic               w_last;

    assign w_accept = req_val && req_rdy;
    assign resp_msg = r_result;

`ifdef ITER_MUL_EARLY_EXIT_EN
    // Stop once no set multiplier bits remain after this cycle's shift.
    assign w_last = (r_cnt == C_LAST) || ((r_b >> 1) == '0);
`else
    assign w_last = (r_cnt == C_LAST);
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        req_rdy     = 1'b0;
        resp_val    = 1'b0;
        case (r_state)
            IDLE: begin
                // Gated so the port reads 0 while reset is held low.
                req_rdy = reset;
                if (w_accept) w_state_nxt = CALC;
            end
            CALC: begin
                if (w_last) w_state_nxt = DONE;
            end
            DONE: begin
                resp_val = 1'b1;
                if (resp_rdy) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_a      <= '0;
            r_b      <= '0;
            r_result <= '0;
            r_cnt    <= '0;
        end else if (r_state == IDLE && w_accept) begin
            r_a      <= req_msg_a;
            r_b      <= req_msg_b;
            r_result <= '0;
            r_cnt    <= '0;
        end else if (r_state == CALC) begin
            if (r_b[0]) r_result <= r_result + r_a;
            r_a   <= r_a << 1;
            r_b   <= r_b >> 1;
            r_cnt <= w_last ? r_cnt : r_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_iter_mul_unit.sv
// Table-driven bench for iter_mul_unit with a scoreboard queue checking product and latency.
module tb_iter_mul_unit;

    localparam int P = 32;

    typedef struct {
        logic [P-1:0] a;
        logic [P-1:0] b;
        logic [P-1:0] exp;
    } vec_t;

    typedef struct {
        logic [P-1:0] msg;
        int           lat;
    } exp_t;

    logic         clk;
    logic         reset;
    logic         req_val;
    logic         req_rdy;
    logic [P-1:0] req_msg_a;
    logic [P-1:0] req_msg_b;
    logic         resp_val;
    logic         resp_rdy;
    logic [P-1:0] resp_msg;

    iter_mul_unit #(.p_nbits(P)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_val   (req_val),
        .req_rdy   (req_rdy),
        .req_msg_a (req_msg_a),
        .req_msg_b (req_msg_b),
        .resp_val  (resp_val),
        .resp_rdy  (resp_rdy),
        .resp_msg  (resp_msg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    exp_t exp_q[$];
    int   acc_q[$];
    bit   resp_seen = 0;
    bit   b2b       = 0;
    bit   hs_valid  = 0;
    int   hs_cyc    = 0;

    task automatic check(input string nm, input logic [P-1:0] act, input logic [P-1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    task automatic fail_now(input string nm);
        checks++;
        failures++;
        $display("FAIL %s actual=timeout required=event", nm);
    endtask

    // Expected CALC cycles: fixed P, or highest set bit of b + 1 (min 1) with early exit.
    function automatic int lat_of(input logic [P-1:0] b);
        int l;
        l = 1;
        for (int i = 0; i < P; i++) if (b[i]) l = i + 1;
`ifdef ITER_MUL_EARLY_EXIT_EN
        return l;
`else
        return (l > 0) ? P : 0;
`endif
    endfunction

    always @(posedge clk) cyc++;

    // Handshakes are judged at the negedge before the edge on which they occur.
    always @(negedge clk) begin
        if (reset) begin
            if (req_val && req_rdy) begin
                acc_q.push_back(cyc + 1);
                if (b2b && hs_valid) check("b2b_idle_gap", P'(cyc + 1 - hs_cyc), P'(1));
            end
            if (resp_val) begin
                if (exp_q.size() == 0 || acc_q.size() == 0) begin
                    check("unexpected_resp", {{(P-1){1'b0}}, resp_val}, '0);
                end else begin
                    if (!resp_seen) begin
                        resp_seen = 1;
                        check("latency", P'(cyc - acc_q[0]), P'(exp_q[0].lat));
                    end
                    if (resp_rdy) begin
                        check("resp_msg", resp_msg, exp_q[0].msg);
                        void'(exp_q.pop_front());
                        void'(acc_q.pop_front());
                        resp_seen = 0;
                        hs_valid  = 1;
                        hs_cyc    = cyc + 1;
                    end
                end
            end
        end
    end

    task automatic run_one(input logic [P-1:0] a, input logic [P-1:0] b,
                           input logic [P-1:0] e, input int stall);
        exp_t x;
        int   n;
        x.msg = e;
        x.lat = lat_of(b);
        exp_q.push_back(x);
        n = 0;
        while (!req_rdy && n < 100) begin @(posedge clk); #1; n++; end
        if (n >= 100) fail_now("wait_req_rdy");
        req_val   = 1'b1;
        req_msg_a = a;
        req_msg_b = b;
        resp_rdy  = (stall == 0);
        @(posedge clk); #1;
        req_val = 1'b0;
        if (stall > 0) begin
            n = 0;
            while (!resp_val && n < 100) begin @(posedge clk); #1; n++; end
            if (n >= 100) fail_now("wait_resp_val");
            for (int i = 0; i < stall; i++) begin
                check("stall_resp_val", {{(P-1){1'b0}}, resp_val}, P'(1));
                check("stall_resp_msg", resp_msg, e);
                check("stall_req_rdy", {{(P-1){1'b0}}, req_rdy}, '0);
                @(posedge clk); #1;
            end
            resp_rdy = 1'b1;
        end
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin @(posedge clk); #1; n++; end
        if (n >= 200) begin
            fail_now("wait_response");
            exp_q.delete();
            acc_q.delete();
            resp_seen = 0;
        end
        @(posedge clk); #1;
        check("idle_req_rdy", {{(P-1){1'b0}}, req_rdy}, P'(1));
    endtask

    vec_t         tbl[8];
    logic [P-1:0] ba[4];
    logic [P-1:0] bb[4];
    logic [P-1:0] be[4];

    initial begin
        int   n;
        exp_t x;

        tbl[0] = '{a: 32'd3,          b: 32'd5,          exp: 32'd15};
        tbl[1] = '{a: 32'hFFFF_FFFF,  b: 32'hFFFF_FFFF,  exp: 32'h0000_0001};
        tbl[2] = '{a: 32'h8000_0000,  b: 32'd2,          exp: 32'h0000_0000};
        tbl[3] = '{a: 32'h0000_1234,  b: 32'd0,          exp: 32'h0000_0000};
        tbl[4] = '{a: 32'd0,          b: 32'h0000_FFFF,  exp: 32'h0000_0000};
        tbl[5] = '{a: 32'h1234_5678,  b: 32'h0000_0010,  exp: 32'h2345_6780};
        tbl[6] = '{a: 32'hDEAD_BEEF,  b: 32'd1,          exp: 32'hDEAD_BEEF};
        tbl[7] = '{a: 32'hFFFF_FFFE,  b: 32'd3,          exp: 32'hFFFF_FFFA};

        ba[0] = 32'd2;         bb[0] = 32'd3;         be[0] = 32'd6;
        ba[1] = 32'h0000_FFFF; bb[1] = 32'h0001_0001; be[1] = 32'hFFFF_FFFF;
        ba[2] = 32'hFFFF_FFFF; bb[2] = 32'hFFFF_FFFF; be[2] = 32'd1;
        ba[3] = 32'd5;         bb[3] = 32'd0;         be[3] = 32'd0;

        reset = 1'b0; req_val = 1'b0; req_msg_a = '0; req_msg_b = '0; resp_rdy = 1'b0;
        #3;
        check("rst_req_rdy", {{(P-1){1'b0}}, req_rdy}, '0);
        check("rst_resp_val", {{(P-1){1'b0}}, resp_val}, '0);
        check("rst_resp_msg", resp_msg, '0);
        repeat (2) @(posedge clk);
        #2 reset = 1'b1;
        #1 check("release_req_rdy", {{(P-1){1'b0}}, req_rdy}, P'(1));
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++) run_one(tbl[i].a, tbl[i].b, tbl[i].exp, 0);

        for (int i = 0; i < 4; i++) begin
            logic [P-1:0] ra, rb;
            ra = $urandom;
            rb = $urandom;
            run_one(ra, rb, ra * rb, 0);
        end

        run_one(32'd6, 32'd7, 32'd42, 10);

        // Abort mid-calculation: no response may follow.
        req_val = 1'b1; req_msg_a = 32'd9; req_msg_b = 32'hFFFF_FFFF; resp_rdy = 1'b1;
        @(posedge clk); #1;
        req_val = 1'b0;
        repeat (10) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        check("abort_resp_val", {{(P-1){1'b0}}, resp_val}, '0);
        check("abort_req_rdy", {{(P-1){1'b0}}, req_rdy}, '0);
        check("abort_resp_msg", resp_msg, '0);
        acc_q.delete();
        exp_q.delete();
        resp_seen = 0;
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("abort_release_rdy", {{(P-1){1'b0}}, req_rdy}, P'(1));
        check("abort_release_val", {{(P-1){1'b0}}, resp_val}, '0);
        run_one(32'd7, 32'd6, 32'd42, 0);

        // Back-to-back with req_val held high across transactions.
        hs_valid = 0;
        b2b      = 1;
        resp_rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            x.msg = be[i];
            x.lat = lat_of(bb[i]);
            exp_q.push_back(x);
        end
        for (int i = 0; i < 4; i++) begin
            req_val   = 1'b1;
            req_msg_a = ba[i];
            req_msg_b = bb[i];
            n = 0;
            while (!req_rdy && n < 100) begin @(posedge clk); #1; n++; end
            if (n >= 100) fail_now("b2b_wait_rdy");
            @(posedge clk); #1;
        end
        req_val = 1'b0;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin @(posedge clk); #1; n++; end
        if (n >= 200) fail_now("b2b_drain");
        b2b = 0;
        @(posedge clk); #1;
        check("b2b_end_rdy", {{(P-1){1'b0}}, req_rdy}, P'(1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
